// File: rtl/rv32_mem_arbiter.sv
// rtl/rv32_mem_arbiter.sv - IF/DM arbiter for one single-port SRAM with LAT-deep read tag pipeline.
// Optional starvation guard for fetch is built when ARB_STARVE_GUARD_EN is defined.
module rv32_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic starve_force;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = if_req && (starve_cnt_q == CW'(STARVE_MAX));

  always_comb begin
    starve_cnt_d = '0;
    if (if_req && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == CW'(STARVE_MAX)) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign starve_force = 1'b0;
`endif

  // Grants are forced low during reset so the pipeline sees no access.
  always_comb begin
    dm_gnt = !rst && dm_req && !starve_force;
    if_gnt = !rst && if_req && !dm_gnt;
  end

  always_comb begin
    mem_en    = if_gnt || dm_gnt;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = if_addr[ADDR_W-1:2];
    mem_wdata = dm_wdata;
    if (dm_gnt) begin
      mem_we   = dm_we;
      mem_be   = dm_be;
      mem_addr = dm_addr[ADDR_W-1:2];
    end else if (if_gnt) begin
      mem_be   = 4'hF;
    end
  end

  // Owner bit: 1 = DM, 0 = IF.
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0] tag_own_q, tag_own_d;

  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = if_gnt || (dm_gnt && !dm_we);
    tag_own_d[0] = dm_gnt;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  assign if_rvalid = tag_vld_q[LAT-1] && !tag_own_q[LAT-1];
  assign dm_rvalid = tag_vld_q[LAT-1] &&  tag_own_q[LAT-1];
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb/tb_rv32_mem_arbiter.sv - randomized scoreboard bench for rv32_mem_arbiter.
module tb_rv32_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LAT    = 3;
  localparam int SM     = 4;
  localparam int DEPTH  = 64;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              dm_req = 1'b0, dm_we = 1'b0;
  logic [3:0]        dm_be = '0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [31:0]       dm_wdata = '0;
  logic              dm_gnt, dm_rvalid;
  logic [31:0]       dm_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  rv32_mem_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM environment: read word appears LAT cycles after the access cycle.
  logic [31:0] sram [DEPTH];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr[5:0]] : $urandom;
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model: word array, starvation count and expected-response queue.
  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic [31:0] ref_mem [DEPTH];
  rsp_t        exp_q [$];
  int          sc = 0;

  always @(negedge clk) begin
    bit force_if, e_if, e_dm;
    int idx;
    if (rst) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_dm_gnt", dm_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      sc = 0;
      exp_q.delete();
    end else begin
      force_if = GUARD && (sc == SM) && if_req;
      e_dm = dm_req && !force_if;
      e_if = if_req && !e_dm;
      chk("if_gnt", if_gnt, e_if);
      chk("dm_gnt", dm_gnt, e_dm);
      chk("mem_en", mem_en, e_if || e_dm);
      if (e_dm) begin
        idx = int'(dm_addr[7:2]);
        chk("dm_mem_addr", mem_addr, dm_addr[31:2]);
        chk("dm_mem_we", mem_we, dm_we);
        chk("dm_mem_be", mem_be, dm_be);
        if (dm_we) begin
          chk("dm_mem_wdata", mem_wdata, dm_wdata);
          for (int b = 0; b < 4; b++)
            if (dm_be[b]) ref_mem[idx][8*b +: 8] = dm_wdata[8*b +: 8];
        end else begin
          exp_q.push_back('{own: 1'b1, data: ref_mem[idx], due: cyc + LAT});
        end
      end else if (e_if) begin
        idx = int'(if_addr[7:2]);
        chk("if_mem_addr", mem_addr, if_addr[31:2]);
        chk("if_mem_we", mem_we, 0);
        chk("if_mem_be", mem_be, 4'hF);
        exp_q.push_back('{own: 1'b0, data: ref_mem[idx], due: cyc + LAT});
      end else begin
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_be", mem_be, 0);
      end
      sc = (if_req && !e_if) ? ((sc < SM) ? sc + 1 : SM) : 0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
    end else if (if_rvalid || dm_rvalid) begin
      chk("single_rvalid", if_rvalid && dm_rvalid, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_owner_dm", dm_rvalid, e.own);
        chk("rsp_cycle", cyc, e.due);
        chk("rsp_data", dm_rvalid ? dm_rdata : if_rdata, e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      chk("missing_rvalid", {if_rvalid, dm_rvalid}, e.own ? 2'b01 : 2'b10);
    end
  end

  task automatic new_if(input int p);
    if_req  = ($urandom_range(99) < p);
    if_addr = ADDR_W'($urandom_range(255));
  endtask

  task automatic new_dm(input int p);
    dm_req   = ($urandom_range(99) < p);
    dm_we    = $urandom_range(1);
    dm_be    = 4'($urandom);
    dm_addr  = ADDR_W'($urandom_range(255));
    dm_wdata = $urandom;
  endtask

  // One cycle of requester behaviour: hold until granted, then maybe issue anew.
  task automatic step(input int p_if, input int p_dm);
    logic gi, gd;
    @(negedge clk);
    gi = if_gnt;
    gd = dm_gnt;
    @(posedge clk);
    #1;
    if (!if_req || gi) new_if(p_if);
    if (!dm_req || gd) new_dm(p_dm);
  endtask

  initial begin
    int  wait_k;
    logic gd;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = 32'h00500093 ^ (i * 32'h01010101);
      ref_mem[i] = 32'h00500093 ^ (i * 32'h01010101);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int n = 0; n < 600; n++) step(50, 50);
    for (int n = 0; n < 12; n++) step(0, 0);

    // Continuous DM stream against a held fetch.
    if_req  = 1'b1;
    if_addr = 32'h100;
    new_dm(100);
    wait_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if_gnt && wait_k == 0) wait_k = k;
      gd = dm_gnt;
      @(posedge clk);
      #1;
      if (wait_k != 0) if_req = 1'b0;
      if (gd) new_dm(100);
    end
    chk("starve_wait_cycles", wait_k, GUARD ? SM + 1 : 0);
    for (int n = 0; n < 12; n++) step(0, 0);

    // Reset while a fetch is in flight; its response must be dropped.
    if_req  = 1'b1;
    if_addr = 32'h104;
    @(negedge clk);
    chk("pre_rst_if_gnt", if_gnt, 1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 8; n++) step(0, 0);

    for (int n = 0; n < 400; n++) step(30, 70);
    for (int n = 0; n < 12; n++) step(0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
